// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// The optional parity bit is enabled with the PARITY_EN macro (see serial_pattern_tx).
package serial_tx_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} tx_state_t;

  localparam int MAX_WIDTH = 32;
  localparam int MAX_GAP   = 15;
  localparam int CNT_W     = $clog2(MAX_WIDTH + 1);
  localparam int GAP_W     = $clog2(MAX_GAP + 1);

  // Narrower words are zero-extended by the caller, so the count is exact.
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Word-in / bit-out bus of the serial pattern transmitter (PARITY_EN changes timing only).
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]           in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       tx_bit;
  logic                       tx_active;
  logic                       tx_last;
  logic [$clog2(WIDTH+1)-1:0] ones_cnt;

  modport master (
    output in_data, in_valid,
    input  in_ready, tx_bit, tx_active, tx_last, ones_cnt
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, tx_bit, tx_active, tx_last, ones_cnt
  );
endinterface

// File: rtl/serial_pattern_tx_shreg.sv
// Parallel-load, shift-left register presenting its MSB; load wins over shift.
module serial_piso_shreg
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);
  logic [WIDTH-1:0] sreg_q, sreg_d;

  always_comb begin
    sreg_d = sreg_q;
    if (load_i)       sreg_d = data_i;
    else if (shift_i) sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) sreg_q <= '0;
    else     sreg_q <= sreg_d;
  end

  assign msb_o = sreg_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first parallel-to-serial transmitter with an idle gap after each frame and a ones count.
// Define PARITY_EN to append an even-parity bit, which then carries tx_last.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  serial_pattern_tx_if.slave bus
);
  localparam int BW = $clog2(WIDTH);
  localparam int OW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  tx_state_t        state_q, state_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [OW-1:0]    ones_q, ones_d;
  logic             accept, last_bit, gap_done, sreg_msb;

  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign last_bit = (bit_q == LAST_BIT);
  assign gap_done = (gap_q == GAP_LAST);

  serial_piso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (accept),
    .shift_i (state_q == SHIFT),
    .data_i  (bus.in_data),
    .msb_o   (sreg_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.in_valid) state_d = SHIFT;
      SHIFT: begin
        if (last_bit) begin
`ifdef PARITY_EN
          state_d = PARITY;
`else
          if (GAP_CYCLES == 0) state_d = IDLE;
          else                 state_d = GAP;
`endif
        end
      end
      PARITY: begin
        if (GAP_CYCLES == 0) state_d = IDLE;
        else                 state_d = GAP;
      end
      GAP:     if (gap_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters restart from zero whenever their state is left, so entry needs no extra load.
  always_comb begin
    bit_d  = (state_q == SHIFT) ? bit_q + BW'(1) : '0;
    gap_d  = (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
    ones_d = accept ? OW'(popcount(MAX_WIDTH'(bus.in_data))) : ones_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_q  <= '0;
      gap_q  <= '0;
      ones_q <= '0;
    end else begin
      bit_q  <= bit_d;
      gap_q  <= gap_d;
      ones_q <= ones_d;
    end
  end

`ifdef PARITY_EN
  logic parity_q, parity_d;

  // Parity is captured at accept since in_data need not be held.
  assign parity_d = accept ? ^bus.in_data : parity_q;

  always_ff @(posedge clk) begin
    if (rst) parity_q <= 1'b0;
    else     parity_q <= parity_d;
  end
`endif

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.tx_bit    = 1'b0;
    bus.tx_active = 1'b0;
    bus.tx_last   = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.tx_bit    = sreg_msb;
        bus.tx_active = 1'b1;
`ifndef PARITY_EN
        bus.tx_last   = last_bit;
`endif
      end
`ifdef PARITY_EN
      PARITY: begin
        bus.tx_bit    = parity_q;
        bus.tx_active = 1'b1;
        bus.tx_last   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.ones_cnt = ones_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: two instances (gap 2 and gap 0) against a frame-queue model.
module tb_serial_pattern_tx;
  localparam int WIDTH = 8;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = WIDTH + PAR;

  typedef logic [2:0] ev_t;   // {tx_bit, tx_active, tx_last}
  typedef ev_t evq_t[$];

  logic             clk;
  logic             rst;
  logic             tb_valid;
  logic [WIDTH-1:0] tb_data;

  serial_pattern_tx_if #(.WIDTH(WIDTH)) b2 ();
  serial_pattern_tx_if #(.WIDTH(WIDTH)) b0 ();

  assign b2.in_data  = tb_data;
  assign b2.in_valid = tb_valid;
  assign b0.in_data  = tb_data;
  assign b0.in_valid = tb_valid;

  serial_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  serial_pattern_tx #(.WIDTH(WIDTH), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // A frame is a list of per-cycle outputs: data MSB-first, optional parity, then gap zeros.
  function automatic evq_t frame(input logic [WIDTH-1:0] d, input int gap);
    evq_t f;
    for (int i = WIDTH - 1; i >= 0; i--) f.push_back({d[i], 1'b1, (i == 0 && PAR == 0)});
    if (PAR != 0) f.push_back({^d, 1'b1, 1'b1});
    for (int g = 0; g < gap; g++) f.push_back(3'b000);
    return f;
  endfunction

  evq_t mq2, mq0;
  int   mones2 = 0;
  int   mones0 = 0;
  bit   mok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq2.delete();
      mq0.delete();
      mones2 <= 0;
      mones0 <= 0;
      mok    <= 1'b1;
    end else begin
      if (mq2.size() != 0) void'(mq2.pop_front());
      else if (tb_valid) begin
        mq2 = frame(tb_data, 2);
        mones2 <= $countones(tb_data);
      end
      if (mq0.size() != 0) void'(mq0.pop_front());
      else if (tb_valid) begin
        mq0 = frame(tb_data, 0);
        mones0 <= $countones(tb_data);
      end
    end
  end

  always @(negedge clk) begin
    if (mok) begin
      chk("ready2", b2.in_ready, mq2.size() == 0);
      chk("out2", {b2.tx_bit, b2.tx_active, b2.tx_last}, (mq2.size() != 0) ? int'(mq2[0]) : 0);
      chk("ones2", b2.ones_cnt, mones2);
      chk("ready0", b0.in_ready, mq0.size() == 0);
      chk("out0", {b0.tx_bit, b0.tx_active, b0.tx_last}, (mq0.size() != 0) ? int'(mq0[0]) : 0);
      chk("ones0", b0.ones_cnt, mones0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!(b2.in_ready && b0.in_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  int         n, cnt1, dcnt, trig;
  logic [8:0] lit;

  initial begin
    // reset with in_valid asserted
    rst = 1'b1; tb_valid = 1'b1; tb_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("rst_bit", b2.tx_bit, 0);
      chk("rst_act", b2.tx_active, 0);
      chk("rst_ones", b2.ones_cnt, 0);
    end
    rst = 1'b0; tb_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", b2.in_ready, 1);

    // single word 0110_0111
    wait_idle();
    tb_valid = 1'b1; tb_data = 8'h67;
    @(negedge clk);
    tb_valid = 1'b0;
    lit = (PAR != 0) ? 9'b011001111 : 9'b001100111;
    for (int i = 0; i < FL; i++) begin
      chk("t2_bit", b2.tx_bit, lit[FL-1-i]);
      chk("t2_last", b2.tx_last, i == FL - 1);
      chk("t2_act", b2.tx_active, 1);
      @(negedge clk);
    end
    chk("t2_ones", b2.ones_cnt, 5);

    // held in_valid: busy for frame + 2 gap cycles, then restart
    wait_idle();
    tb_valid = 1'b1; tb_data = 8'hC3;
    @(negedge clk);
    n = 0;
    while (!b2.in_ready && n < 100) begin
      if (n >= FL) chk("t3_gapbit", b2.tx_bit, 0);
      @(negedge clk);
      n++;
    end
    chk("t3_busy", n, FL + 2);
    tb_data = 8'h1F;
    @(negedge clk);
    chk("t3_restart", b2.tx_active, 1);
    chk("t3_ones", b2.ones_cnt, 5);
    tb_valid = 1'b0;

    // gap 0 back-to-back FF then 00
    wait_idle();
    tb_valid = 1'b1; tb_data = 8'hFF;
    @(negedge clk);
    tb_data = 8'h00;
    cnt1 = 0;
    for (int i = 0; i < 2 * FL + 1; i++) begin
      cnt1 += int'(b0.tx_bit);
      if (i == 0) chk("t4_ones_ff", b0.ones_cnt, 8);
      if (i == FL) begin
        chk("t4_bubble_act", b0.tx_active, 0);
        chk("t4_bubble_rdy", b0.in_ready, 1);
        chk("t4_bubble_bit", b0.tx_bit, 0);
      end
      if (i == FL + 1) begin
        chk("t4_ones_00", b0.ones_cnt, 0);
        chk("t4_second", b0.tx_active, 1);
      end
      @(negedge clk);
    end
    tb_valid = 1'b0;
    chk("t4_ones_seen", cnt1, 8);

    // reset on the 4th data bit of A5
    wait_idle();
    tb_valid = 1'b1; tb_data = 8'hA5;
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_bit4", b2.tx_bit, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_act", b2.tx_active, 0);
    chk("t5_ready", b2.in_ready, 1);
    chk("t5_last", b2.tx_last, 0);
    chk("t5_ones", b2.ones_cnt, 0);

    // loopback into a "more than one 1" detector
    wait_idle();
    tb_valid = 1'b1; tb_data = 8'h41;
    @(negedge clk);
    tb_valid = 1'b0;
    dcnt = 0; trig = -1;
    for (int i = 0; i < FL; i++) begin
      if (i < WIDTH && b2.tx_active && b2.tx_bit) dcnt++;
      if (dcnt > 1 && trig < 0) trig = i;
      if (b2.tx_last) chk("t6_det_vs_ones", dcnt > 1, b2.ones_cnt > 1);
      @(negedge clk);
    end
    chk("t6_trig", trig, 7);
    chk("t6_ones", b2.ones_cnt, 2);

    // random traffic with occasional resets
    wait_idle();
    for (int i = 0; i < 400; i++) begin
      tb_valid = ($urandom_range(0, 3) != 0);
      tb_data  = WIDTH'($urandom);
      rst      = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    rst = 1'b0; tb_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
